// File: rtl/traffic_pkg.sv
// Shared constants for the traffic lamp / countdown display block:
// lamp bit map, segment encodings and a binary-to-BCD helper.
package traffic_pkg;

    localparam int MAIN_R = 5;
    localparam int MAIN_Y = 4;
    localparam int MAIN_G = 3;
    localparam int CTRY_R = 2;
    localparam int CTRY_Y = 1;
    localparam int CTRY_G = 0;

    localparam logic [5:0] ALL_RED = 6'b100100;

    // Active-high segments {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Count never exceeds 31, so three compares replace a divider.
    function automatic bcd_t to_bcd(input logic [4:0] v);
        bcd_t       r;
        logic [4:0] rem;
        if (v >= 5'd30) begin
            r.tens = 2'd3;
            rem    = v - 5'd30;
        end else if (v >= 5'd20) begin
            r.tens = 2'd2;
            rem    = v - 5'd20;
        end else if (v >= 5'd10) begin
            r.tens = 2'd1;
            rem    = v - 5'd10;
        end else begin
            r.tens = 2'd0;
            rem    = v;
        end
        r.ones = rem[3:0];
        return r;
    endfunction

endpackage

// File: rtl/traffic_if.sv
// Controller-to-display bundle: countdown and lamp request in, segment,
// digit enable, lamp drive and fault flag out.
interface traffic_if;
    logic [4:0] countdown_time;
    logic [5:0] led_light;
    logic [6:0] seg;
    logic [1:0] an;
    logic [5:0] led_out;
    logic       fault;

    modport master (
        output countdown_time, led_light,
        input  seg, an, led_out, fault
    );

    modport slave (
        input  countdown_time, led_light,
        output seg, an, led_out, fault
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern, with a blank override
// used for leading-zero suppression.
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/traffic_display.sv
// Two-digit multiplexed countdown display plus lamp driver with green
// blinking near phase end and a sticky conflict interlock.
module traffic_display
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned BLINK_DIV    = 16,
    parameter int unsigned BLINK_THRESH = 3
) (
    input  logic      clk,
    input  logic      rst,
    traffic_if.slave  bus
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [4:0]         cnt_q, cnt_d;
    logic [5:0]         led_q, led_d;
    logic               cap_vld_q, cap_vld_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic               digit_q, digit_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         an_q, an_d;
    logic [5:0]         led_out_q, led_out_d;
    logic               fault_q, fault_d;

    bcd_t       bcd;
    logic [3:0] digit_bcd;
    logic       blank_digit;
    logic [6:0] seg_dec;
    logic       in_blink;
    logic       conflict;
    logic [5:0] blink_mask;

    // Capture stage; cap_vld_q keeps the all-zero reset capture from
    // being mistaken for a conflicting lamp request.
    always_comb begin
        cnt_d     = bus.countdown_time;
        led_d     = bus.led_light;
        cap_vld_d = 1'b1;
    end

    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            digit_d = ~digit_q;
        end
    end

    // A new count restarts the blink with the lamp on; the restart is
    // decided at capture time so the first on-half is a full period.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_ph_d  = blink_ph_q;
        if (bus.countdown_time != cnt_q) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_comb begin
        bcd         = to_bcd(cnt_q);
        digit_bcd   = digit_q ? {2'b00, bcd.tens} : bcd.ones;
        blank_digit = digit_q && (bcd.tens == 2'd0);
    end

    seg7_decode u_seg7 (
        .bcd   (digit_bcd),
        .blank (blank_digit),
        .seg   (seg_dec)
    );

    always_comb begin
        seg_d = seg_dec;
        an_d  = digit_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        in_blink = (cnt_q != 5'd0) && (32'(cnt_q) <= BLINK_THRESH);
        conflict = cap_vld_q &&
                   ((led_q[MAIN_G] && led_q[CTRY_G]) ||
                    (led_q[MAIN_R:MAIN_G] == 3'b000) ||
                    (led_q[CTRY_R:CTRY_G] == 3'b000));
        blink_mask = 6'b000000;
        if (in_blink && blink_ph_q) begin
            blink_mask[MAIN_G] = 1'b1;
            blink_mask[CTRY_G] = 1'b1;
        end
        fault_d = fault_q | conflict;
        if (!cap_vld_q || fault_q || conflict) begin
            led_out_d = ALL_RED;
        end else begin
            led_out_d = led_q & ~blink_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            led_q       <= '0;
            cap_vld_q   <= 1'b0;
            scan_q      <= '0;
            digit_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= 2'b10;
            led_out_q   <= ALL_RED;
            fault_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            cap_vld_q   <= cap_vld_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            led_out_q   <= led_out_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.led_out = led_out_q;
    assign bus.fault   = fault_q;

endmodule

// File: doc/traffic_display.md
TRAFFIC_DISPLAY -- requirements
Module: traffic_display

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit is held before the scan moves to the next digit; legal range >= 2.
REQ-002 Parameter BLINK_DIV, default 16: clock cycles per blink half-period; legal range >= 2.
REQ-003 Parameter BLINK_THRESH, default 3: green lamps blink while the countdown is in 1..BLINK_THRESH.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 countdown_time  in  5  remaining seconds of the current phase, from the controller.
REQ-007 led_light  in  6  lamp request from the controller: [5:3] main road {R,Y,G}, [2:0] country road {R,Y,G}.
REQ-008 seg  out  7  active-high segments {g,f,e,d,c,b,a} for the selected digit.
REQ-009 an  out  2  active-low digit enables: an[1] tens, an[0] ones.
REQ-010 led_out  out  6  physical lamp drive, same bit map as led_light.
REQ-011 fault  out  1  sticky flag; set on a conflicting lamp request.

Function
REQ-012 countdown_time and led_light shall be registered into capture registers every cycle; every output derives from the captured values.
REQ-013 Latency from an input change to seg, an and led_out shall be exactly 2 cycles: one capture cycle, then one output-register cycle.
REQ-014 The captured count 0..31 shall be converted to BCD: tens = 0..3, ones = 0..9.
REQ-015 Scan counter: counts 0..SCAN_DIV-1, then wraps; on each wrap, the active digit toggles between ones and tens.
REQ-016 Exactly one bit of an shall be low at any time; it is never 2'b00 after reset.
REQ-017 Leading-zero blanking: when tens = 0, the tens slot drives seg = 7'b0000000 while its an bit is still low.
REQ-018 A captured count of 0 shall display a blank tens digit and ones = "0" (7'b0111111).
REQ-019 Segment codes shall be:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
REQ-020 Blink phase counter: counts 0..BLINK_DIV-1 and toggles blink_phase on each wrap.
REQ-021 Whenever the captured count differs from its previous captured value, the blink counter and blink_phase shall reset to 0 and 0 (phase = lamp on).
REQ-022 While the captured count is in 1..BLINK_THRESH:
  - any requested green shall be driven as (request AND NOT blink_phase);
  - red and yellow shall pass through unchanged.
REQ-023 Outside 1..BLINK_THRESH, led_out shall equal the captured led_light.
REQ-024 Conflict: a captured led_light with both greens set, or with a road having no lamp set.
  - The block shall drive led_out = 6'b100100 (both red) that cycle.
  - It shall set fault.
REQ-025 fault shall stay at 1 until rst, and led_out shall be forced to 6'b100100 while fault = 1.
REQ-026 If a count change and a blink-counter wrap fall on the same cycle, the count-change restart (REQ-021) shall take priority.

Reset
REQ-027 With rst = 1 at a rising edge, the next state shall be:
  - capture registers = 0; scan and blink counters = 0; blink_phase = 0;
  - seg = 0, an = 2'b10 (ones active), led_out = 6'b100100, fault = 0.
REQ-028 Reset asserted mid-scan or mid-blink shall abandon the current state immediately, with no partial digit.
REQ-029 Counting shall resume on the first cycle after rst deasserts.

Structure
REQ-030 Shared package traffic_pkg shall hold:
  - lamp bit indices (MAIN_R = 5 .. CTRY_G = 0);
  - ALL_RED = 6'b100100;
  - the ten segment constants and SEG_BLANK.
REQ-031 Sub-module seg7_decode: purely combinational, 4-bit BCD to 7-bit seg, with a blank input; one instance.
REQ-032 Target size of traffic_display without the sub-module: 120-250 lines.

Verification
REQ-033 Scenario 1 (reset): rst held for 3 cycles -> an = 10, led_out = 100100, fault = 0, seg = 0.
REQ-034 Scenario 2 (display): countdown_time = 25, led_light = 100001.
  - After 2 cycles, the ones slot shows 5 (1101101) and the tens slot shows 2 (1011011).
  - Each slot is held for 4 cycles.
REQ-035 Scenario 3 (blanking): countdown_time = 7 -> the tens slot shows 0000000 and the ones slot 0000111; countdown_time = 0 -> ones shows 0111111.
REQ-036 Scenario 4 (blink): countdown_time = 2, led_light = 001100.
  - led_out = 001100 for 16 cycles, then 000100 for 16 cycles, repeating.
  - Stepping the count to 1 restarts with the lamp on.
REQ-037 Scenario 5 (conflict): led_light = 001001.
  - Two cycles later, led_out = 100100 and fault = 1.
  - Both hold after led_light returns to 100001, until rst.
REQ-038 Scenario 6 (boundary): countdown_time = 31 -> tens 3 (1001111), ones 1 (0000110), no blinking.
